nos_palette_encoder: RTL
========================

NOS_PALETTE_ENCODER -- requirements
Module: nos_palette_encoder

Interface
REQ-001 Parameter DEPTH, default 2160, SHALL be the number of pixels per sprite frame (write addresses 0..DEPTH-1).
REQ-002 Parameter AW, default 12, SHALL be the address width; DEPTH-1 SHALL fit in AW bits.
REQ-003 Port Clk  input  1  SHALL be the single clock; all state updates on posedge Clk.
REQ-004 Port Reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Port start  input  1  SHALL be a one-cycle request to begin encoding a frame.
REQ-006 Port pix_valid  input  1  SHALL mark pix_rgb as valid.
REQ-007 Port pix_rgb  input  24  SHALL carry the RGB888 pixel, {R,G,B}.
REQ-008 Port pix_ready  output  1  SHALL indicate the block accepts a pixel this cycle.
REQ-009 Port wr_en  output  1  SHALL be the sprite-memory write strobe.
REQ-010 Port wr_address  output  AW  SHALL be the sprite-memory write address.
REQ-011 Port wr_data  output  4  SHALL be the palette index to write.
REQ-012 Port busy  output  1  SHALL be high from start acceptance until done.
REQ-013 Port done  output  1  SHALL pulse for one cycle when a frame completes.
REQ-014 Port miss_count  output  AW  SHALL count pixels in the current/last frame that matched no palette entry.

Function
REQ-015 Palette SHALL be fixed: 0=ff0000, 1=2d83f1, 2=052a60, 3=7c4621, 4=ebd0bc, 5=ffffff, 6=000000, 7=4a4a46, 8=6ea3ea.
REQ-016 Encoding SHALL be exact 24-bit equality; the lowest matching index wins; a pixel matching no entry SHALL encode as 0 and increment miss_count.
REQ-017 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-018 IDLE -> RUN on start; miss_count, accept counter and write address counter SHALL clear to 0 on that edge.
REQ-019 start while not in IDLE SHALL be ignored.
REQ-020 pix_ready SHALL be 1 only in RUN; a pixel is accepted on a cycle with pix_valid && pix_ready.
REQ-021 RUN -> DRAIN on the edge accepting pixel number DEPTH-1 (zero-based); pix_ready SHALL be 0 from the next cycle.
REQ-022 Pipeline SHALL be two stages: stage 1 registers pixel and 9-bit match vector; stage 2 registers priority-encoded index, address and wr_en.
REQ-023 Pixel accepted at edge N SHALL produce wr_en=1 with its wr_address/wr_data during the cycle after edge N+2 (fixed 2-cycle latency); pipeline SHALL never stall.
REQ-024 wr_address SHALL be the sequence 0,1,...,DEPTH-1 in acceptance order, no wrap and no skipped addresses regardless of pix_valid gaps.
REQ-025 wr_en SHALL be 0 on every cycle with no corresponding accepted pixel.
REQ-026 DRAIN -> DONE when the write for address DEPTH-1 is issued; DONE SHALL assert done=1 for exactly one cycle then return to IDLE.
REQ-027 busy SHALL be 1 in RUN, DRAIN and DONE, 0 in IDLE.
REQ-028 miss_count SHALL update in stage 2 with the write, SHALL hold after frame end until the next accepted start, max value DEPTH (no overflow).
REQ-029 pix_valid in IDLE, DRAIN or DONE SHALL have no effect.

Reset
REQ-030 Reset_n low SHALL immediately force state IDLE, pix_ready=0, wr_en=0, wr_address=0, wr_data=0, busy=0, done=0, miss_count=0, and clear pipeline valids.
REQ-031 Reset mid-frame SHALL discard in-flight pixels; no write SHALL occur after Reset_n rises until a new start.

Verification
REQ-032 Full frame, pix_valid held high, all pixels 2d83f1 -> 2160 writes, addresses 0..2159, wr_data=1, first wr_en 2 cycles after first acceptance, done one pulse, miss_count=0.
REQ-033 Pixels 123456, ff0000, 000000, 6ea3ea -> wr_data 0,0,6,8; miss_count=1.
REQ-034 pix_valid toggled randomly -> addresses contiguous, count of wr_en equals accepted count, latency always 2.
REQ-035 start pulsed during RUN and DRAIN -> no counter clear, frame completes normally.
REQ-036 Reset_n low at pixel 1000 -> all outputs 0 asynchronously; after release and new start, addresses restart at 0.
REQ-037 DEPTH=4 build, 4 pixels back-to-back -> done pulses once exactly one cycle after write to address 3, then busy=0.

Source files
------------

// File: rtl/nos_palette_encoder.sv
// Sprite palette encoder: maps RGB888 pixels onto a fixed 9-entry palette and
// streams 4-bit indices into sprite memory at a fixed pipeline latency.
module nos_palette_encoder #(
    parameter int unsigned DEPTH = 2160,
    parameter int unsigned AW    = 12
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          start,
    input  logic          pix_valid,
    input  logic [23:0]   pix_rgb,
    output logic          pix_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_address,
    output logic [3:0]    wr_data,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] miss_count
);

    localparam int unsigned NCOL = 9;
    localparam int unsigned IW   = 4;
    localparam logic [AW-1:0] LAST     = AW'(DEPTH - 1);
    localparam logic [AW-1:0] MISS_MAX = AW'(DEPTH);
    // Entry 0 is the rightmost element.
    localparam logic [NCOL-1:0][23:0] PALETTE = {
        24'h6ea3ea, 24'h4a4a46, 24'h000000, 24'hffffff, 24'hebd0bc,
        24'h7c4621, 24'h052a60, 24'h2d83f1, 24'hff0000
    };

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state;
    logic [AW-1:0]   acc_cnt;
    logic [AW-1:0]   wr_cnt;
    logic            s0_valid;
    logic [23:0]     s0_rgb;
    logic            s1_valid;
    logic [NCOL-1:0] s1_match;
    logic            accept_c;
    logic            start_c;
    logic [NCOL-1:0] match_c;
    logic [IW-1:0]   index_c;

    assign accept_c = pix_valid && pix_ready;
    assign start_c  = start && (state == IDLE);

    always_comb begin
        match_c = '0;
        for (int i = 0; i < NCOL; i++) begin
            match_c[i] = (s0_rgb == PALETTE[i]);
        end
    end

    // Scan from the top so the lowest matching entry is the one that sticks.
    always_comb begin
        index_c = '0;
        for (int i = NCOL - 1; i >= 0; i--) begin
            if (s1_match[i]) begin
                index_c = IW'(i);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            pix_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            acc_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        pix_ready <= 1'b1;
                        busy      <= 1'b1;
                        acc_cnt   <= '0;
                    end
                end
                RUN: begin
                    if (accept_c) begin
                        acc_cnt <= acc_cnt + AW'(1);
                        if (acc_cnt == LAST) begin
                            state     <= DRAIN;
                            pix_ready <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (wr_en && (wr_address == LAST)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Capture, match and write stages; never stalls once a pixel is taken.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s0_valid   <= 1'b0;
            s0_rgb     <= '0;
            s1_valid   <= 1'b0;
            s1_match   <= '0;
            wr_en      <= 1'b0;
            wr_address <= '0;
            wr_data    <= '0;
            wr_cnt     <= '0;
            miss_count <= '0;
        end else begin
            s0_valid <= accept_c;
            if (accept_c) begin
                s0_rgb <= pix_rgb;
            end
            s1_valid <= s0_valid;
            if (s0_valid) begin
                s1_match <= match_c;
            end
            wr_en <= s1_valid;
            if (s1_valid) begin
                wr_address <= wr_cnt;
                wr_data    <= index_c;
                wr_cnt     <= wr_cnt + AW'(1);
                if ((s1_match == '0) && (miss_count != MISS_MAX)) begin
                    miss_count <= miss_count + AW'(1);
                end
            end
            if (start_c) begin
                wr_cnt     <= '0;
                miss_count <= '0;
            end
        end
    end

endmodule
